// File: rtl/tone_pkg.sv
// Shared types and board-level constants for the beep tone receive path.
package tone_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } tone_state_e;

  localparam int CLK_HZ         = 16_000_000;
  localparam int BEEP_PERIOD    = 65536;
  localparam int DEF_CNT_W      = 20;
  localparam int DEF_TOL        = 512;
  localparam int DEF_LOCK_COUNT = 4;
  localparam int DEF_TIMEOUT    = (1 << 20) - 1;

endpackage

// File: rtl/tone_meter_sync_edge.sv
// Two-flop synchroniser for the asynchronous tone line plus a delay flop
// that turns a synchronised low-to-high transition into a one-cycle pulse.
module sync_edge (
  input  logic CLK,
  input  logic RST,
  input  logic async_i,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/tone_meter.sv
// Measures the period of an external square wave in CLK cycles, declares lock
// after LOCK_COUNT consecutive in-tolerance periods, and flags loss of tone.
module tone_meter
  import tone_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int TARGET     = BEEP_PERIOD,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TONE_IN,
  output logic [CNT_W-1:0] PERIOD,
  output logic             PERIOD_VALID,
  output logic             TONE_LOCK,
  output logic             NO_TONE,
  output tone_state_e      STATE_DBG
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   TARGET_X  = (CNT_W + 1)'(TARGET);
  localparam logic [CNT_W:0]   TOL_X     = (CNT_W + 1)'(TOL);
  localparam logic [3:0]       LOCK_C    = 4'(LOCK_COUNT);

  logic rise;

  sync_edge u_sync_edge (
    .CLK     (CLK),
    .RST     (RST),
    .async_i (TONE_IN),
    .rise_o  (rise)
  );

  tone_state_e      state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [CNT_W-1:0] period_q,  period_d;
  logic             valid_q,   valid_d;
  logic             lock_q,    lock_d;
  logic             no_tone_q, no_tone_d;
  logic [3:0]       match_q,   match_d;

  logic             timed_out;
  logic [CNT_W:0]   cnt_x;
  logic [CNT_W:0]   diff;
  logic             in_tol;

  // Counter is capped at TIMEOUT by the timeout branch, so it never wraps.
  assign timed_out = (cnt_q == TIMEOUT_C);

  // One extra bit keeps the subtraction unsigned and wrap-free.
  assign cnt_x  = {1'b0, cnt_q};
  assign diff   = (cnt_x >= TARGET_X) ? (cnt_x - TARGET_X) : (TARGET_X - cnt_x);
  assign in_tol = (diff <= TOL_X);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a rise on the timeout cycle keeps us measuring.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (!rise && timed_out) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    lock_d    = lock_q;
    no_tone_d = no_tone_q;
    match_d   = match_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = rise ? CNT_W'(1) : '0;
      end
      ST_MEASURE: begin
        if (rise) begin
          period_d  = cnt_q;
          valid_d   = 1'b1;
          no_tone_d = 1'b0;
          cnt_d     = CNT_W'(1);
          if (in_tol) begin
            match_d = (match_q >= LOCK_C) ? LOCK_C : match_q + 4'd1;
          end else begin
            match_d = '0;
          end
          lock_d = (match_d == LOCK_C);
        end else if (timed_out) begin
          cnt_d     = '0;
          no_tone_d = 1'b1;
          lock_d    = 1'b0;
          match_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      lock_q    <= 1'b0;
      no_tone_q <= 1'b1;
      match_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      lock_q    <= lock_d;
      no_tone_q <= no_tone_d;
      match_q   <= match_d;
    end
  end

  assign PERIOD       = period_q;
  assign PERIOD_VALID = valid_q;
  assign TONE_LOCK    = lock_q;
  assign NO_TONE      = no_tone_q;
  assign STATE_DBG    = state_q;

endmodule

// File: tb/tb_tone_meter.sv
// Directed-plus-random bench for tone_meter; a timestamp-based reference model
// predicts every output on every cycle.
module tb_tone_meter;
  import tone_pkg::*;

  localparam int CNT_W = 10;
  localparam int TGT   = 100;
  localparam int TOLV  = 2;
  localparam int LC    = 4;
  localparam int TMO   = 1000;

  // clock / reset
  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic tone = 1'b0;

  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             tone_lock;
  logic             no_tone;
  tone_state_e      state_dbg;

  always #5 clk = ~clk;

  tone_meter #(
    .CNT_W      (CNT_W),
    .TARGET     (TGT),
    .TOL        (TOLV),
    .LOCK_COUNT (LC),
    .TIMEOUT    (TMO)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .TONE_IN      (tone),
    .PERIOD       (period),
    .PERIOD_VALID (period_valid),
    .TONE_LOCK    (tone_lock),
    .NO_TONE      (no_tone),
    .STATE_DBG    (state_dbg)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_valid  = 0;

  // reference model: events are timestamps of synchronised rises
  int         pend_q[$];
  bit         hist_q[$];
  bit         m_prev   = 1'b0;
  bit         m_active = 1'b0;
  int         m_last   = 0;
  logic [31:0] m_period = 0;
  logic        m_valid  = 1'b0;
  logic        m_lock   = 1'b0;
  logic        m_nt     = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit ev;
    int per;
    int d;
    bit all_ok;
    cyc++;
    m_valid = 1'b0;
    if (rst) begin
      pend_q.delete();
      hist_q.delete();
      m_prev   = 1'b0;
      m_active = 1'b0;
      m_period = 0;
      m_lock   = 1'b0;
      m_nt     = 1'b1;
    end else begin
      ev = (pend_q.size() > 0) && (pend_q[0] == cyc);
      if (ev) void'(pend_q.pop_front());
      if (ev && !m_active) begin
        m_active = 1'b1;
        m_last   = cyc;
      end else if (ev) begin
        per      = cyc - m_last;
        m_period = per;
        m_valid  = 1'b1;
        m_nt     = 1'b0;
        d        = (per > TGT) ? per - TGT : TGT - per;
        hist_q.push_back(d <= TOLV);
        if (hist_q.size() > LC) void'(hist_q.pop_front());
        all_ok = (hist_q.size() == LC);
        foreach (hist_q[i]) if (!hist_q[i]) all_ok = 1'b0;
        m_lock = all_ok;
        m_last = cyc;
      end else if (m_active && (cyc - m_last == TMO)) begin
        m_active = 1'b0;
        m_nt     = 1'b1;
        m_lock   = 1'b0;
        hist_q.delete();
      end
      // a sampled low-to-high transition shows up two edges later
      if (tone && !m_prev) pend_q.push_back(cyc + 2);
      m_prev = tone;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (period_valid === 1'b1) n_valid++;
    chk("period",       32'(period),       m_period);
    chk("period_valid", 32'(period_valid), 32'(m_valid));
    chk("tone_lock",    32'(tone_lock),    32'(m_lock));
    chk("no_tone",      32'(no_tone),      32'(m_nt));
    chk("state",        32'(state_dbg),    m_active ? 32'(ST_MEASURE) : 32'(ST_IDLE));
  endtask

  // driver: one full period p with a random high time
  task automatic drive_period(input int p);
    int h;
    h = $urandom_range(1, p - 1);
    tone = 1'b1;
    repeat (h) tick();
    tone = 1'b0;
    repeat (p - h) tick();
  endtask

  initial begin
    // reset held 3 cycles with the input toggling
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tone = ~tone;
      tick();
    end
    rst  = 1'b0;
    tone = 1'b0;
    repeat (5) tick();

    // lock on a clean 100-cycle tone: 6 rises give 5 reports
    n_valid = 0;
    repeat (6) drive_period(100);
    chk("lock_pulses", 32'(n_valid), 32'd5);
    chk("lock_up",     32'(tone_lock), 32'd1);

    // tolerance edges, then relock
    drive_period(98);
    drive_period(102);
    drive_period(103);
    repeat (5) drive_period(100);
    chk("relock", 32'(tone_lock), 32'd1);

    // timeout with the line held low
    tone = 1'b0;
    repeat (1010) tick();
    chk("timeout_nt",     32'(no_tone),   32'd1);
    chk("timeout_lock",   32'(tone_lock), 32'd0);
    chk("timeout_period", 32'(period),    32'd100);
    n_valid = 0;
    drive_period(150);
    chk("first_rise_silent", 32'(n_valid), 32'd0);
    drive_period(100);
    chk("second_rise_reports", 32'(n_valid), 32'd1);

    // boundaries: fastest period, then a period equal to the timeout
    repeat (10) drive_period(2);
    drive_period(TMO);
    drive_period(100);
    chk("tmo_boundary_nt", 32'(no_tone), 32'd0);

    // randomized periods around and away from the target
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) drive_period($urandom_range(2, 300));
      else                           drive_period($urandom_range(TGT - 4, TGT + 4));
    end

    // mid-measurement reset during lock
    repeat (5) drive_period(100);
    tone = 1'b1;
    repeat (10) tick();
    tone = 1'b0;
    repeat (40) tick();
    rst = 1'b1;
    tick();
    chk("rst_lock", 32'(tone_lock), 32'd0);
    chk("rst_nt",   32'(no_tone),   32'd1);
    rst = 1'b0;
    repeat (4) drive_period(100);
    chk("relock_not_yet", 32'(tone_lock), 32'd0);
    drive_period(100);
    chk("relock_after_5", 32'(tone_lock), 32'd1);

    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
